// File: rtl/event_monitor_pkg.sv
// Shared definitions for the event monitor bank and its drain arbiter:
// default event width, drain FSM state encoding and beat-count helper.
package event_monitor_pkg;

    localparam int TS_W      = 32;
    localparam int ID_W      = 8;
    localparam int PROBE_W   = 32;
    localparam int EVT_W_DEF = TS_W + ID_W + PROBE_W;

    // HDR is only entered when the header beat is compiled in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } drain_state_e;

    // Number of out_w-bit beats needed to carry one evt_w-bit event.
    function automatic int num_beats(input int evt_w, input int out_w);
        return (evt_w + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search starting at a registered
// priority pointer; the pointer advances past the winner on ptr_update.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ptr_update,
    input  logic [IDX_W-1:0] upd_idx,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Source with highest priority on the next arbitration (0 after reset).
    logic [IDX_W-1:0] ptr_reg;
    logic             found;
    int               idx;

    // Pick the first requesting source at or after ptr_reg, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

    // Move priority to the source just after the one granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (ptr_update) begin
            ptr_reg <= (upd_idx == IDX_W'(N - 1)) ? '0 : upd_idx + 1'b1;
        end
    end

endmodule

// File: rtl/event_drain_arbiter.sv
// Drains N_SRC event FIFOs round-robin into one OUT_W-bit valid/ready
// stream, LS word first, with out_last on the final beat of each event.
// Optional: define EVT_DRAIN_HDR_EN to prefix each event with a header beat
// {zero pad, NUM_BEATS[7:0], source index[7:0]}.
module event_drain_arbiter
    import event_monitor_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int EVT_W = EVT_W_DEF,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16,
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_en,
    input  logic                   halt,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*EVT_W-1:0] src_data,
    output logic [N_SRC-1:0]       src_pop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_last,
    output logic [SRC_W-1:0]       out_src,
    output logic                   busy,
    output logic [CNT_W-1:0]       drained_cnt
);

    localparam int NUM_BEATS = num_beats(EVT_W, OUT_W);
    localparam int SH_W      = NUM_BEATS * OUT_W;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    drain_state_e      state_reg, state_next;
    logic [SH_W-1:0]   sh_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic [CNT_W-1:0]  drained_reg;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  gnt;
    logic [SRC_W-1:0]  gnt_idx;
    logic              grant;

    assign req         = src_valid & src_en;
    assign busy        = (state_reg != IDLE);
    assign drained_cnt = drained_reg;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ptr_update (grant),
        .upd_idx    (gnt_idx),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

`ifdef EVT_DRAIN_HDR_EN
    logic [OUT_W-1:0] hdr_word;

    // Header beat payload built from the latched source index.
    always_comb begin
        hdr_word       = '0;
        hdr_word[15:0] = {8'(NUM_BEATS), 8'(out_src)};
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, pop strobe and stream outputs; pops are held off in reset.
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        src_pop    = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = sh_reg[OUT_W-1:0];
        case (state_reg)
            IDLE: begin
                if (rst_n && !halt && (req != '0)) begin
                    grant      = 1'b1;
                    src_pop    = gnt;
`ifdef EVT_DRAIN_HDR_EN
                    state_next = HDR;
`else
                    state_next = SEND;
`endif
                end
            end
`ifdef EVT_DRAIN_HDR_EN
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_word;
                if (out_ready) begin
                    state_next = SEND;
                end
            end
`endif
            SEND: begin
                out_valid = 1'b1;
                out_last  = (beat_reg == LAST_BEAT);
                if (out_ready && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted event, then shift out one word per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg      <= '0;
            beat_reg    <= '0;
            out_src     <= '0;
            drained_reg <= '0;
        end else if (grant) begin
            sh_reg  <= SH_W'(src_data[int'(gnt_idx)*EVT_W +: EVT_W]);
            out_src <= gnt_idx;
        end else if ((state_reg == SEND) && out_ready) begin
            sh_reg <= sh_reg >> OUT_W;
            if (out_last) begin
                beat_reg <= '0;
                if (drained_reg != '1) begin
                    drained_reg <= drained_reg + 1'b1;
                end
            end else begin
                beat_reg <= beat_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_drain_arbiter.sv
// Directed bench for event_drain_arbiter: table of arbitration vectors plus
// hand-written backpressure, halt, reset-abort and fairness sequences.
module tb_event_drain_arbiter;

    localparam int N  = 4;
    localparam int EW = 72;
    localparam int OW = 32;
    localparam int CW = 16;
    localparam int NB = 3;
`ifdef EVT_DRAIN_HDR_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    src_en;
    logic            halt;
    logic [N-1:0]    src_valid;
    logic [N*EW-1:0] src_data;
    logic [N-1:0]    src_pop;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_src;
    logic            busy;
    logic [CW-1:0]   drained_cnt;

    logic [EW-1:0]   src_word [N];
    bit   [3:0]      pat = 4'b1001;   // ready pattern 1,0,0,1 (bit 0 first)
    int              errors = 0;
    int              checks = 0;
    int              exp_drained = 0;
    int              pop_cnt;
    int              cnt [N];

    event_drain_arbiter #(.N_SRC(N), .EVT_W(EW), .OUT_W(OW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_en      (src_en),
        .halt        (halt),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_pop     (src_pop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_src     (out_src),
        .busy        (busy),
        .drained_cnt (drained_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        src_data = '0;
        for (int i = 0; i < N; i++) src_data[i*EW +: EW] = src_word[i];
    end

    // Count every pop the DUT issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pop_cnt <= 0;
        else        pop_cnt <= pop_cnt + $countones(src_pop);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One event from source s; called at a negedge with inputs settled.
    task automatic run_event(input int s, input bit stall, input bit halt_mid);
        logic [95:0] ext;
        logic [31:0] exp_d;
        bit          exp_l;
        bit          acc;
        int          k;
        ext = {24'h0, src_word[s]};
        k   = 0;
        check("pop_onehot", src_pop, 1 << s);
        check("busy_idle", busy, 0);
        @(posedge clk); @(negedge clk);
        if (halt_mid) halt = 1'b1;
        for (int b = 0; b < NB + HB; b++) begin
            if (HB == 1 && b == 0) exp_d = {16'h0, 8'(NB), 8'(s)};
            else                   exp_d = ext[(b-HB)*32 +: 32];
            exp_l = (b == NB + HB - 1);
            acc   = 1'b0;
            while (!acc) begin
                out_ready = stall ? pat[k % 4] : 1'b1;
                k++;
                check("out_valid", out_valid, 1);
                check("out_data", out_data, exp_d);
                check("out_last", out_last, exp_l);
                check("out_src", out_src, s);
                check("no_pop_in_send", src_pop, 0);
                acc = out_ready;
                @(posedge clk); @(negedge clk);
            end
        end
        out_ready = 1'b1;
        exp_drained++;
        check("busy_after", busy, 0);
        check("drained_cnt", drained_cnt, exp_drained);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] en;
        logic       hlt;
        int         exp_src;   // -1: no grant expected
    } vec_t;

    vec_t tbl [10];

    initial begin
        src_word[0] = 72'h10_0A0B0C0D_01020304;
        src_word[1] = 72'h21_1A1B1C1D_11121314;
        src_word[2] = 72'hAB_CDEF0123_45678899;
        src_word[3] = 72'h3C_3A3B3C3D_31323334;

        // Priority pointer starts at 0 and moves past each winner.
        tbl[0] = '{4'b0100, 4'b1111, 1'b0,  2};
        tbl[1] = '{4'b1111, 4'b1111, 1'b0,  3};
        tbl[2] = '{4'b1111, 4'b1111, 1'b0,  0};
        tbl[3] = '{4'b1111, 4'b1111, 1'b0,  1};
        tbl[4] = '{4'b1111, 4'b1111, 1'b0,  2};
        tbl[5] = '{4'b0100, 4'b1011, 1'b0, -1};
        tbl[6] = '{4'b0101, 4'b1011, 1'b0,  0};
        tbl[7] = '{4'b1001, 4'b1111, 1'b0,  3};
        tbl[8] = '{4'b0011, 4'b1111, 1'b1, -1};
        tbl[9] = '{4'b0011, 4'b1111, 1'b0,  0};

        rst_n = 1'b0; src_en = '0; halt = 1'b0; src_valid = '0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drained", drained_cnt, 0);
        check("rst_pop", src_pop, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arbitration table.
        for (int i = 0; i < 10; i++) begin
            src_valid = tbl[i].valid; src_en = tbl[i].en; halt = tbl[i].hlt;
            #1;
            if (tbl[i].exp_src < 0) begin
                check("pop_none", src_pop, 0);
                @(posedge clk); @(negedge clk);
                check("busy_none", busy, 0);
            end else begin
                run_event(tbl[i].exp_src, 1'b0, 1'b0);
            end
        end

        // Backpressure on source 1 with ready pattern 1,0,0,1.
        src_valid = 4'b0010; src_en = 4'b1111; halt = 1'b0; #1;
        run_event(1, 1'b1, 1'b0);

        // halt raised mid-SEND: event completes, then nothing is granted.
        src_valid = 4'b0100; #1;
        run_event(2, 1'b0, 1'b1);
        src_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("halt_no_pop", src_pop, 0);
            @(posedge clk); @(negedge clk);
            check("halt_idle", busy, 0);
        end
        halt = 1'b0;

        // Reset after the first beat of a source 3 event is accepted.
        src_valid = 4'b1000; #1;
        check("abort_pop", src_pop, 4'b1000);
        @(posedge clk); @(negedge clk);
        check("abort_valid_pre", out_valid, 1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0; #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_drained", drained_cnt, 0);
        check("abort_pop_held", src_pop, 0);
        src_valid = '0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_drained = 0;
        @(negedge clk);

        // Fairness: 3 events queued per source, continuous ready.
        for (int i = 0; i < N; i++) cnt[i] = 3;
        for (int e = 0; e < 12; e++) begin
            for (int i = 0; i < N; i++) src_valid[i] = (cnt[i] != 0);
            #1;
            run_event(e % 4, 1'b0, 1'b0);
            cnt[e % 4]--;
        end
        src_valid = '0;
        check("fair_pop_total", pop_cnt, 12);
        check("fair_drained", drained_cnt, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/event_drain_arbiter.md
Name: event_drain_arbiter

Overview:
- Shares one outbound word stream among N_SRC event monitor cores by draining their event FIFOs under round-robin arbitration.
- Each granted event is popped once, latched, and serialized into OUT_W-bit beats with valid/ready handshake and a last flag.
- Sits between the bank of monitor cores and the host readout path (bus bridge or trace DMA).

Parameters:
- N_SRC, 4, number of monitor cores drained (>=2)
- EVT_W, 72, event width per core (TS_W+ID_W+PROBE_W = 32+8+32)
- OUT_W, 32, output beat width; NUM_BEATS = ceil(EVT_W/OUT_W)
- CNT_W, 16, width of the drained-event counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_en  in  N_SRC  per-source drain enable mask
- halt  in  1  stop issuing new grants; the transfer in flight completes
- src_valid  in  N_SRC  per-core evt_valid (FIFO non-empty)
- src_data  in  N_SRC*EVT_W  per-core evt_data (head-of-FIFO peek); source i at [i*EVT_W +: EVT_W]
- src_pop  out  N_SRC  one-hot single-cycle pop to core's evt_pop
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  beat payload
- out_last  out  1  final beat of event
- out_src  out  SRC_W  granted source index; SRC_W = max(1,$clog2(N_SRC))
- busy  out  1  FSM not in IDLE
- drained_cnt  out  CNT_W  events fully transmitted, saturating

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, rr pointer=0 (source 0 has highest priority first), beat counter=0, shift register=0.
- req = src_valid & src_en. FSM states: IDLE, SEND.
- IDLE, when halt=0 and req!=0:
  - Grant the first set req bit searching from (last_grant+1) mod N_SRC upward with wrap.
  - In the same cycle: src_pop[g]=1, latch src_data[g] into the shift register, out_src<=g, last_grant<=g, go to SEND.
  - Exactly one src_pop bit is high, for exactly one cycle.
- IDLE, when halt=1 or req==0: stay in IDLE; src_pop=0.
- SEND:
  - out_valid=1.
  - out_data = shift register [OUT_W-1:0]: LS word first, upper bits of the final beat zero-padded.
  - out_last=1 when beat counter == NUM_BEATS-1.
  - On out_valid&&out_ready: shift right by OUT_W and increment the counter.
  - On the last handshake: counter<=0, drained_cnt<=drained_cnt+1 (saturates at all-ones), go to IDLE.
- out_data, out_src and out_last must hold stable while out_valid=1 && out_ready=0 (AXI-stream rule).
- Latency: pop at cycle t, first beat valid at t+1. Throughput is at most one event per NUM_BEATS+1 cycles (one IDLE bubble between events).
- The IDLE bubble guarantees src_valid/src_data of the popped core have settled before the next arbitration.
- Changes to src_en or halt mid-SEND do not affect the current event. src_en is sampled only in IDLE.
- A source whose src_valid drops after its grant is unaffected: the data was latched at pop time.
- Async reset mid-SEND: the FSM returns to IDLE, the partially sent event is lost, and out_valid drops immediately.
- NUM_BEATS==1 is legal: SEND lasts one accepted beat with out_last=1.

Optional Feature:
- Macro: EVT_DRAIN_HDR_EN.
- Defined: each event is preceded by one header beat.
  - Header out_data = {zero pad, NUM_BEATS[7:0], out_src zero-extended to 8 bits}.
  - Header beat has out_last=0; total beats per event = NUM_BEATS+1.
  - FSM gains state HDR between IDLE and SEND; same handshake rules apply.
- Undefined: no header beat and no HDR state; out_src is the only source attribution.

Decomposition:
- Shared package event_monitor_pkg:
  - EVT_W default derivation from TS_W/ID_W/PROBE_W.
  - drain_state_e enum (IDLE, HDR, SEND).
  - Helper function num_beats(evt_w, out_w).
- Sub-module rr_arbiter #(N): inputs req and ptr_update with grant index; outputs one-hot gnt and gnt_idx. Combinational select plus registered last_grant pointer.

Test Plan:
- Single source: EVT_W=72, OUT_W=32, src 2 holds 0xAB_CDEF0123_45678899, out_ready=1 -> src_pop=4'b0100 for one cycle; beats 0x45678899, 0xCDEF0123, 0x000000AB (last); out_src=2; drained_cnt=1.
- Fairness: all four sources hold 3 events each, continuous ready -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; 12 pops; drained_cnt=12.
- Backpressure: out_ready toggles 1,0,0,1 -> each beat's data stays stable while stalled; no extra pops; beat count per event stays 3.
- halt/src_en: assert halt mid-SEND -> current event completes, no further src_pop while halted. With src_en=4'b1011 and src 2 valid -> src 2 is never popped.
- Reset mid-SEND after beat 1 accepted -> out_valid=0, busy=0, drained_cnt=0 immediately; next event drains cleanly from beat 0.
- EVT_DRAIN_HDR_EN: src 1 event -> header 0x00000301, then 3 data beats; out_last only on the 4th beat.
